// File: rtl/ex_mem_stage.sv
// Execute/Memory pipeline stage: NUM_CH result channels plus one load/store channel.
// Define EX_MEM_SKID_EN to add a one-entry skid buffer that removes the mem_ready -> ex_ready path.
module ex_mem_stage #(
  parameter int NUM_CH    = 3,
  parameter int DATA_W    = 16,
  parameter int TAG_W     = 5,
  parameter int LS_DATA_W = 8,
  parameter int ADDR_W    = 25,
  parameter int CNT_W     = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     ex_valid,
  output logic                     ex_ready,
  input  logic [NUM_CH-1:0]        ex_ch_en,
  input  logic [NUM_CH*DATA_W-1:0] ex_res,
  input  logic [NUM_CH*TAG_W-1:0]  ex_tag,
  input  logic                     ex_ls_en,
  input  logic                     ex_ls_r_nw,
  input  logic [LS_DATA_W-1:0]     ex_ls_data,
  input  logic [TAG_W-1:0]         ex_ls_tag,
  input  logic [ADDR_W-1:0]        ex_ls_addr,
  output logic                     mem_valid,
  input  logic                     mem_ready,
  output logic [NUM_CH-1:0]        mem_ch_vld,
  output logic [NUM_CH*DATA_W-1:0] mem_res,
  output logic [NUM_CH*TAG_W-1:0]  mem_tag,
  output logic                     mem_ls_vld,
  output logic                     mem_ls_r_nw,
  output logic [LS_DATA_W-1:0]     mem_ls_data,
  output logic [TAG_W-1:0]         mem_ls_tag,
  output logic [ADDR_W-1:0]        mem_ls_addr,
  output logic [CNT_W-1:0]         stall_cnt
);

  localparam int BEAT_W = NUM_CH + NUM_CH*DATA_W + NUM_CH*TAG_W + 1 + LS_DATA_W + TAG_W + ADDR_W + 1;

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
`ifdef EX_MEM_SKID_EN
  localparam logic [1:0] ST_FULL  = 2'd2;
`endif

  logic [1:0]        state_q, state_d;
  logic [BEAT_W-1:0] m_beat_q, m_beat_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic [BEAT_W-1:0] in_beat;
  logic              accept;

  logic [NUM_CH-1:0]        m_ch_en;
  logic [NUM_CH*DATA_W-1:0] m_res;
  logic [NUM_CH*TAG_W-1:0]  m_tag;
  logic                     m_ls_en;
  logic [LS_DATA_W-1:0]     m_ls_data;
  logic [TAG_W-1:0]         m_ls_tag;
  logic [ADDR_W-1:0]        m_ls_addr;
  logic                     m_ls_r_nw;

  assign in_beat = {ex_ch_en, ex_res, ex_tag, ex_ls_en, ex_ls_data, ex_ls_tag, ex_ls_addr, ex_ls_r_nw};
  assign {m_ch_en, m_res, m_tag, m_ls_en, m_ls_data, m_ls_tag, m_ls_addr, m_ls_r_nw} = m_beat_q;

  assign mem_valid = (state_q != ST_EMPTY);

`ifdef EX_MEM_SKID_EN
  logic [BEAT_W-1:0] s_beat_q, s_beat_d;

  // Ready depends only on registered state, so the skid entry absorbs a late stall.
  assign ex_ready = (state_q != ST_FULL) & ~flush & ~rst;
`else
  assign ex_ready = (~mem_valid | mem_ready) & ~flush & ~rst;
`endif

  assign accept = ex_valid & ex_ready;

  always_comb begin
    state_d  = state_q;
    m_beat_d = m_beat_q;
`ifdef EX_MEM_SKID_EN
    s_beat_d = s_beat_q;
`endif
    // Flush only drops occupancy; the data fields keep their last loaded contents.
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            m_beat_d = in_beat;
            state_d  = ST_ONE;
          end
        end
        ST_ONE: begin
          if (mem_ready) begin
            if (accept) m_beat_d = in_beat;
            else        state_d  = ST_EMPTY;
          end
`ifdef EX_MEM_SKID_EN
          else if (accept) begin
            s_beat_d = in_beat;
            state_d  = ST_FULL;
          end
`endif
        end
`ifdef EX_MEM_SKID_EN
        ST_FULL: begin
          if (mem_ready) begin
            m_beat_d = s_beat_q;
            state_d  = ST_ONE;
          end
        end
`endif
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (mem_valid && !mem_ready && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_EMPTY;
      m_beat_q    <= '0;
      stall_cnt_q <= '0;
`ifdef EX_MEM_SKID_EN
      s_beat_q    <= '0;
`endif
    end else begin
      state_q     <= state_d;
      m_beat_q    <= m_beat_d;
      stall_cnt_q <= stall_cnt_d;
`ifdef EX_MEM_SKID_EN
      s_beat_q    <= s_beat_d;
`endif
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      assign mem_ch_vld[gi] = mem_valid & m_ch_en[gi];
      assign mem_tag[gi*TAG_W +: TAG_W] = mem_ch_vld[gi] ? m_tag[gi*TAG_W +: TAG_W] : '0;
    end
  endgenerate

  assign mem_res     = m_res;
  assign mem_ls_vld  = mem_valid & m_ls_en;
  assign mem_ls_tag  = mem_ls_vld ? m_ls_tag : '0;
  assign mem_ls_data = m_ls_data;
  assign mem_ls_addr = m_ls_addr;
  assign mem_ls_r_nw = m_ls_r_nw;
  assign stall_cnt   = stall_cnt_q;

endmodule

// File: doc/ex_mem_stage.md
# ex_mem_stage

Parametrised Execute/Memory pipeline stage for the CPU, between the execute units and the memory/writeback side. Carries NUM_CH result channels (data, destination tag, valid) plus one load/store channel (data, tag, SDRAM address, read/not-write) under a valid/ready handshake. Replaces the bare stall-hold register with per-channel valids, synchronous flush, an optional one-entry skid buffer and a saturating backpressure counter.

## Interface
Parameters:
- NUM_CH, 3, number of execute result channels (A0, A1, M)
- DATA_W, 16, result data width
- TAG_W, 5, destination tag width; tag 0 means no writeback
- LS_DATA_W, 8, load/store data width
- ADDR_W, 25, SDRAM address width
- CNT_W, 16, stall counter width

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  synchronous reset, active-high
- flush  in  1  synchronous pipeline flush
- ex_valid  in  1  upstream beat valid
- ex_ready  out  1  stage can accept a beat
- ex_ch_en  in  NUM_CH  per-channel result valid
- ex_res  in  NUM_CH*DATA_W  channel results; channel i at [i*DATA_W +: DATA_W]
- ex_tag  in  NUM_CH*TAG_W  channel destination tags, same packing
- ex_ls_en, ex_ls_r_nw  in  1 each  load/store valid; 1 = read, 0 = write
- ex_ls_data  in  LS_DATA_W  store data / load passthrough
- ex_ls_tag  in  TAG_W  load destination tag
- ex_ls_addr  in  ADDR_W  SDRAM address
- mem_valid  out  1  output beat valid
- mem_ready  in  1  downstream accepts beat
- mem_ch_vld  out  NUM_CH; mem_res  out  NUM_CH*DATA_W; mem_tag  out  NUM_CH*TAG_W
- mem_ls_vld, mem_ls_r_nw  out  1 each; mem_ls_data  out  LS_DATA_W; mem_ls_tag  out  TAG_W; mem_ls_addr  out  ADDR_W
- stall_cnt  out  CNT_W  saturating count of backpressure cycles

## Operation
- Beat = {ch_en, res, tag, ls_en, ls_data, ls_tag, ls_addr, ls_r_nw}. Accept = ex_valid & ex_ready. Beats with all enables 0 are accepted and passed like any other beat.
- Main register M drives mem_*; skid register S (macro-dependent). States: EMPTY (M invalid), ONE (M valid, S empty), FULL (M and S valid).
- EMPTY: accept -> M<=in, ONE.
- ONE: mem_ready & accept -> M<=in, stay ONE; mem_ready & !accept -> EMPTY; !mem_ready & accept -> S<=in, FULL; else hold.
- FULL: no accept; mem_ready -> M<=S, ONE; else hold.
- Output gating: mem_ch_vld[i] = mem_valid & M.ch_en[i]; mem_ls_vld = mem_valid & M.ls_en; mem_tag[i] = 0 unless mem_ch_vld[i]; mem_ls_tag = 0 unless mem_ls_vld. mem_res, mem_ls_data, mem_ls_addr, mem_ls_r_nw hold last loaded value.
- Flush (priority below rst, above everything else): state -> EMPTY, M and S valids cleared, ex_ready forced 0 in that cycle, no beat accepted, data fields untouched, stall_cnt unaffected.
- stall_cnt increments each cycle mem_valid & !mem_ready, saturates at 2^CNT_W-1, clears only on rst.

## Timing
- Reset: state EMPTY, mem_valid 0, all mem_* 0, stall_cnt 0, ex_ready 0 during rst, 1 the cycle after.
- Latency: beat accepted at edge N appears on mem_* after edge N; throughput 1 beat/cycle when mem_ready held high.
- Handshake: beat leaves on edge where mem_valid & mem_ready; mem_* stable while mem_valid & !mem_ready.
- Simultaneous flush and mem_ready: flush wins, beat in M is discarded (not counted as transferred).
- rst mid-FULL: both entries lost, outputs zero next cycle.

## Configuration
- EX_MEM_SKID_EN defined: S present; ex_ready = (state != FULL) & !flush, registered state only (no combinational mem_ready -> ex_ready path). After FULL drains, ex_ready returns high the following cycle.
- Not defined: no S, states EMPTY/ONE only; ex_ready = (!mem_valid | mem_ready) & !flush, combinational from mem_ready. Otherwise identical.

## Test plan
- Reset: hold rst 2 cycles with random inputs -> all mem_* 0, mem_valid 0, stall_cnt 0; ex_ready 1 cycle after release.
- Streaming: 8 beats back-to-back, ch_en=3'b101, res ch0=16'h1000+k, tag ch0=5'd3, mem_ready=1 -> mem_valid each cycle 1 cycle late, mem_tag ch1=0, data in order.
- Backpressure (SKID_EN): mem_ready=0 for 4 cycles during stream -> exactly 2 beats held (M,S), ex_ready 0 from 2nd stalled cycle, stall_cnt=4, no loss/dup on release.
- Load/store: beat ls_en=1, r_nw=0, addr=25'h1ABCDEF, data=8'h5A, tag=5'd7 -> mem_ls_* match, mem_ls_tag=7; then bubble beat ls_en=0 -> mem_ls_tag=0, addr holds 25'h1ABCDEF.
- Flush: flush with FULL and ex_valid=1 -> next cycle mem_valid 0, incoming beat not accepted, stall_cnt unchanged.
- Saturation: CNT_W=4, mem_ready=0 for 20 cycles with mem_valid=1 -> stall_cnt stops at 15.
